alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Execute-stage ALU that consumes the 4-bit Operation code produced by the ALU control decoder.
//   Performs AND/OR/ADD/SUB in one cycle and SLL iteratively, one bit per cycle.
//   Flags zero for beq resolution and illegal for unsupported codes.
//   Valid/ready handshake on input and output, so a multi-cycle shift stalls the pipeline cleanly.
// PARAMETERS
//   WIDTH    64                 operand/result width in bits
//   SHAMT_W  6                  shift-amount bits taken from b; equals $clog2(WIDTH)
// PORTS
//   clk        in   1        single clock; all state updates on rising edge
//   reset      in   1        synchronous, active-high reset
//   in_valid   in   1        operation request valid
//   in_ready   out  1        unit can accept a request (high only in IDLE)
//   operation  in   4        0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1000 SLL; others illegal
//   a          in   WIDTH    operand A (shift source for SLL)
//   b          in   WIDTH    operand B; SLL uses b[SHAMT_W-1:0] as the shift amount
//   out_valid  out  1        result valid; held until out_ready
//   out_ready  in   1        consumer accepts result
//   result     out  WIDTH    registered result
//   zero       out  1        (result == 0); valid with out_valid
//   illegal    out  1        operation code was unsupported; valid with out_valid
//   busy       out  1        high in SHIFT or DONE
// BEHAVIOUR
//   Reset: state=IDLE; in_ready=1; out_valid=0; result=0; zero=0; illegal=0; busy=0; shift counter=0.
//   Accept: in_valid && in_ready sampled at edge T; a, b, and operation are captured at that edge.
//   FSM states: IDLE, SHIFT, DONE.
//     IDLE -> DONE on accept of AND/OR/ADD/SUB/illegal, or SLL with shamt==0.
//       result is computed and registered at edge T; out_valid is visible in cycle T+1.
//     IDLE -> SHIFT on accept of SLL with shamt n>0: acc=a, cnt=n.
//     SHIFT: each edge acc<<=1 (zero-fill), cnt-=1; when cnt reaches 0, go to DONE with result=acc.
//       For n>0, out_valid is visible in cycle T+1+n.
//     DONE: out_valid=1; result, zero, and illegal are held stable.
//       On out_ready, go to IDLE, with out_valid=0 in the next cycle.
//     IDLE stays IDLE when in_valid=0.
//   No accept while out_valid is high: in_ready=0 in DONE even when out_ready=1 (one idle cycle between ops).
//   Arithmetic: ADD/SUB are modulo 2^WIDTH; carry/borrow is discarded; SUB = a + ~b + 1.
//   SLL: shift amount is b[SHAMT_W-1:0] only; upper bits of b are ignored.
//     b=64 is treated as shamt 0, so result=a.
//   Illegal code: result=0, zero=1, illegal=1; uses the DONE path with the same 1-cycle latency.
//   illegal=0 for all legal codes.
//   Inputs are ignored outside the accept edge; changing a/b/operation during SHIFT has no effect.
//   Reset mid-operation: an in-flight shift or undelivered result is discarded.
//     In the cycle after reset deasserts: IDLE, in_ready=1, out_valid=0.
//   out_ready while out_valid=0 is ignored.
// TESTING
//   1 ADD a=5,b=7 accepted at T -> out_valid in cycle T+1, result=12, zero=0, illegal=0.
//   2 SUB a=9,b=9 -> result=0, zero=1. SUB a=0,b=1 -> result=all ones (wrap), zero=0.
//   3 SLL a=1,b=5 at T -> in_ready=0 for cycles T+1..T+6, out_valid in T+6, result=32.
//     SLL a=3,b=64 -> out_valid at T+1, result=3.
//   4 AND a=0xF0,b=0x3C -> 0x30; then OR on the same operands -> 0xFC.
//     Hold out_ready=0 for 3 cycles -> result/out_valid stable, in_ready=0; release -> IDLE next cycle.
//   5 operation=4'b0011 -> out_valid at T+1, result=0, illegal=1, zero=1.
//     Following legal ADD -> illegal=0.
//   6 Assert reset during SHIFT (SLL b=40, 10 cycles in) -> next cycle in_ready=1, out_valid=0.
//     A fresh ADD then completes normally.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, bit-serial SLL, valid/ready on both sides.
// Flags zero for branch resolution and illegal for unsupported operation codes.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned SHAMT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         operation,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               illegal,
    output logic               busy
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     acc;
    logic [SHAMT_W-1:0]   cnt;

    logic [WIDTH-1:0]     alu_c;
    logic                 legal_c;
    logic [SHAMT_W-1:0]   shamt_c;
    logic [WIDTH-1:0]     acc_next_c;

    assign shamt_c    = b[SHAMT_W-1:0];
    assign acc_next_c = acc << 1;

    // Single-cycle datapath; SLL here only covers the zero-shift case.
    always_comb begin
        alu_c   = '0;
        legal_c = 1'b1;
        unique case (operation)
            OP_AND:  alu_c = a & b;
            OP_OR:   alu_c = a | b;
            OP_ADD:  alu_c = a + b;
            OP_SUB:  alu_c = a + ~b + WIDTH'(1);
            OP_SLL:  alu_c = a;
            default: begin
                alu_c   = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (operation == OP_SLL && shamt_c != '0) begin
                            state <= SHIFT;
                            acc   <= a;
                            cnt   <= shamt_c;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_c;
                            zero      <= (alu_c == '0);
                            illegal   <= ~legal_c;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next_c;
                    cnt <= cnt - SHAMT_W'(1);
                    // Last shift lands directly in the result register.
                    if (cnt == SHAMT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_next_c;
                        zero      <= (acc_next_c == '0);
                        illegal   <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized ops against an arithmetic reference.
module tb_alu_exec_unit;

    localparam int unsigned WIDTH   = 64;
    localparam int unsigned SHAMT_W = 6;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1000;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic             busy;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operation (operation),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arithmetic on the operation code.
    function automatic logic [WIDTH-1:0] ref_result(input logic [3:0] op,
                                                    input logic [WIDTH-1:0] x,
                                                    input logic [WIDTH-1:0] y);
        case (op)
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_ADD:  return x + y;
            OP_SUB:  return x - y;
            OP_SLL:  return x << y[SHAMT_W-1:0];
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_illegal(input logic [3:0] op);
        return !(op == OP_AND || op == OP_OR || op == OP_ADD || op == OP_SUB || op == OP_SLL);
    endfunction

    // Cycles from the accept edge until out_valid is observed.
    function automatic int ref_latency(input logic [3:0] op, input logic [WIDTH-1:0] y);
        if (op == OP_SLL) return int'(y[SHAMT_W-1:0]) + 1;
        return 1;
    endfunction

    // Present one request for one edge, then scramble the inputs.
    task automatic issue(input logic [3:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        in_valid  = 1'b1;
        operation = op;
        a         = x;
        b         = y;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operation = 4'($urandom);
        a         = {$urandom, $urandom};
        b         = {$urandom, $urandom};
    endtask

    // Count cycles until out_valid; notes whether in_ready was ever seen high meanwhile.
    task automatic wait_valid(output int lat, output bit rdy_low);
        lat     = 1;
        rdy_low = 1'b1;
        forever begin
            if (in_ready) rdy_low = 1'b0;
            if (out_valid || lat >= 200) break;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (result !== '0 || zero !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got result=%h zero=%b illegal=%b busy=%b expected all 0", result, zero, illegal, busy);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_add();
        int lat; bit rdy_low;
        issue(OP_ADD, 64'd5, 64'd7);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency got %0d expected 1", lat); end
        checks++; if (result !== 64'd12) begin errors++; $display("FAIL add_result got %h expected %h", result, 64'd12); end
        checks++; if (zero !== 1'b0 || illegal !== 1'b0) begin errors++; $display("FAIL add_flags got zero=%b illegal=%b expected 0/0", zero, illegal); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL add_busy got busy=%b in_ready=%b expected 1/0", busy, in_ready); end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL add_release got out_valid=%b in_ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_sub();
        int lat; bit rdy_low;
        issue(OP_SUB, 64'd9, 64'd9);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 1 || result !== '0 || zero !== 1'b1) begin
            errors++; $display("FAIL sub_equal got lat=%0d result=%h zero=%b expected 1/0/1", lat, result, zero);
        end
        release_out();
        issue(OP_SUB, 64'd0, 64'd1);
        wait_valid(lat, rdy_low);
        checks++; if (result !== {WIDTH{1'b1}} || zero !== 1'b0) begin
            errors++; $display("FAIL sub_wrap got result=%h zero=%b expected all ones/0", result, zero);
        end
        release_out();
    endtask

    task automatic test_sll();
        int lat; bit rdy_low;
        issue(OP_SLL, 64'd1, 64'd5);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 6) begin errors++; $display("FAIL sll5_latency got %0d expected 6", lat); end
        checks++; if (rdy_low !== 1'b1) begin errors++; $display("FAIL sll5_in_ready got high during op expected low"); end
        checks++; if (result !== 64'd32 || zero !== 1'b0 || illegal !== 1'b0) begin
            errors++; $display("FAIL sll5_result got %h zero=%b illegal=%b expected %h/0/0", result, zero, illegal, 64'd32);
        end
        release_out();
        issue(OP_SLL, 64'd3, 64'd64);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 1 || result !== 64'd3) begin
            errors++; $display("FAIL sll64_as_zero got lat=%0d result=%h expected 1/%h", lat, result, 64'd3);
        end
        release_out();
        issue(OP_SLL, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFC1);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 2 || result !== 64'd2) begin
            errors++; $display("FAIL sll_upper_b_ignored got lat=%0d result=%h expected 2/%h", lat, result, 64'd2);
        end
        release_out();
    endtask

    task automatic test_logic_hold();
        int lat; bit rdy_low; bit stable;
        issue(OP_AND, 64'hF0, 64'h3C);
        wait_valid(lat, rdy_low);
        checks++; if (result !== 64'h30) begin errors++; $display("FAIL and_result got %h expected %h", result, 64'h30); end
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            operation = OP_ADD;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h30) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin
            errors++; $display("FAIL hold_stable got out_valid=%b in_ready=%b result=%h expected 1/0/%h", out_valid, in_ready, result, 64'h30);
        end
        release_out();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        issue(OP_OR, 64'hF0, 64'h3C);
        wait_valid(lat, rdy_low);
        checks++; if (result !== 64'hFC) begin errors++; $display("FAIL or_result got %h expected %h", result, 64'hFC); end
        release_out();
    endtask

    task automatic test_illegal();
        int lat; bit rdy_low;
        issue(4'b0011, 64'd123, 64'd456);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 1 || result !== '0 || illegal !== 1'b1 || zero !== 1'b1) begin
            errors++; $display("FAIL illegal_op got lat=%0d result=%h illegal=%b zero=%b expected 1/0/1/1", lat, result, illegal, zero);
        end
        release_out();
        issue(OP_ADD, 64'd1, 64'd1);
        wait_valid(lat, rdy_low);
        checks++; if (illegal !== 1'b0 || result !== 64'd2) begin
            errors++; $display("FAIL after_illegal got illegal=%b result=%h expected 0/%h", illegal, result, 64'd2);
        end
        release_out();
    endtask

    task automatic test_reset_mid_shift();
        int lat; bit rdy_low; bit quiet;
        issue(OP_SLL, 64'hDEAD_BEEF, 64'd40);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_shift_reset got in_ready=%b out_valid=%b busy=%b expected 1/0/0", in_ready, out_valid, busy);
        end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL mid_shift_discard got stale activity expected idle"); end
        issue(OP_ADD, 64'd100, 64'd23);
        wait_valid(lat, rdy_low);
        checks++; if (lat !== 1 || result !== 64'd123) begin
            errors++; $display("FAIL add_after_reset got lat=%0d result=%h expected 1/%h", lat, result, 64'd123);
        end
        release_out();
    endtask

    task automatic test_random();
        logic [3:0]       ops [6] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL, OP_SLL};
        logic [3:0]       op;
        logic [WIDTH-1:0] x, y, exp;
        int lat, hold; bit rdy_low, stable;
        for (int n = 0; n < 60; n++) begin
            op = (n % 7 == 6) ? 4'($urandom) : ops[$urandom_range(0, 5)];
            x  = {$urandom, $urandom};
            y  = {$urandom, $urandom};
            if (n % 5 == 0) y = x;
            exp = ref_result(op, x, y);
            issue(op, x, y);
            wait_valid(lat, rdy_low);
            checks++; if (lat !== ref_latency(op, y) || rdy_low !== 1'b1) begin
                errors++; $display("FAIL rand_latency op=%b got %0d rdy_low=%b expected %0d/1", op, lat, rdy_low, ref_latency(op, y));
            end
            checks++; if (result !== exp || zero !== (exp == '0) || illegal !== ref_illegal(op)) begin
                errors++; $display("FAIL rand_result op=%b a=%h b=%h got %h z=%b il=%b expected %h z=%b il=%b",
                                   op, x, y, result, zero, illegal, exp, (exp == '0), ref_illegal(op));
            end
            hold   = $urandom_range(0, 3);
            stable = 1'b1;
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'($urandom);
                @(posedge clk);
                #1;
                if (out_valid !== 1'b1 || result !== exp) stable = 1'b0;
            end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL rand_hold got out_valid=%b result=%h expected 1/%h", out_valid, result, exp); end
            release_out();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        operation = '0;
        a         = '0;
        b         = '0;
        test_reset();
        test_add();
        test_sub();
        test_sll();
        test_logic_hold();
        test_illegal();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
